// File: rtl/wb_result_bus_arbiter_if.sv
// Result-bus interface: NUM_REQ producer handshakes plus one registered output port.
interface wb_result_bus_arbiter_if #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned RS_ID_WIDTH = 5,
  parameter int unsigned DATA_WIDTH  = 32
);
  localparam int unsigned SrcW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                  req_valid;
  logic [NUM_REQ-1:0]                  req_ready;
  logic [NUM_REQ-1:0][RS_ID_WIDTH-1:0] req_rs_id;
  logic [NUM_REQ-1:0][4:0]             req_addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data;

  logic                   out_valid;
  logic                   out_ready;
  logic [RS_ID_WIDTH-1:0] out_rs_id;
  logic [4:0]             out_addr;
  logic [DATA_WIDTH-1:0]  out_data;
  logic [SrcW-1:0]        out_src;

  // Producers and result consumer.
  modport master (
    output req_valid, req_rs_id, req_addr, req_data, out_ready,
    input  req_ready, out_valid, out_rs_id, out_addr, out_data, out_src
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_rs_id, req_addr, req_data, out_ready,
    output req_ready, out_valid, out_rs_id, out_addr, out_data, out_src
  );
endinterface

// File: rtl/wb_result_bus_arbiter.sv
// Round-robin arbiter sharing one result-bus write port, followed by a 2-entry buffer
// so that out_ready never reaches req_ready combinationally.
module wb_result_bus_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned RS_ID_WIDTH = 5,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input logic                     clk,
  input logic                     rst_n,
  input logic                     flush,
  wb_result_bus_arbiter_if.slave  bus
);
  localparam int unsigned SrcW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic [RS_ID_WIDTH-1:0] rs_id;
    logic [4:0]             addr;
    logic [DATA_WIDTH-1:0]  data;
    logic [SrcW-1:0]        src;
  } entry_t;

  entry_t          fifo_q [2];
  entry_t          fifo_d [2];
  logic [1:0]      count_q, count_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [SrcW-1:0] ptr_q, ptr_d;

  logic [SrcW-1:0] gnt_idx;
  logic            gnt_found;
  logic            grant_en;
  logic            push;
  logic            pop;
  entry_t          head;

  // Winner search: first valid requester starting at ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    logic [SrcW-1:0] idx_s;
    idx       = 0;
    idx_s     = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_s = SrcW'(idx);
      if (!gnt_found && bus.req_valid[idx_s]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx_s;
      end
    end
  end

  // Grant depends only on registered occupancy, flush and req_valid.
  assign grant_en = (count_q != 2'd2) && !flush;
  assign push     = grant_en && gnt_found;
  assign pop      = (count_q != 2'd0) && bus.out_ready;

  // One-hot ready to the winner.
  always_comb begin
    bus.req_ready = '0;
    if (push) bus.req_ready[gnt_idx] = 1'b1;
  end

  // Next state for buffer, occupancy and round-robin pointer.
  always_comb begin
    fifo_d   = fifo_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ptr_d    = ptr_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = '{rs_id: bus.req_rs_id[gnt_idx],
                             addr:  bus.req_addr[gnt_idx],
                             data:  bus.req_data[gnt_idx],
                             src:   gnt_idx};
        wr_ptr_d = ~wr_ptr_q;
        ptr_d    = (gnt_idx == SrcW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset clears the buffer so out_* read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      count_q   <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      ptr_q     <= '0;
    end else begin
      fifo_q[0] <= fifo_d[0];
      fifo_q[1] <= fifo_d[1];
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ptr_q     <= ptr_d;
    end
  end

  assign head          = fifo_q[rd_ptr_q];
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_rs_id = head.rs_id;
  assign bus.out_addr  = head.addr;
  assign bus.out_data  = head.data;
  assign bus.out_src   = head.src;
endmodule

// File: tb/tb_wb_result_bus_arbiter.sv
// Directed bench for wb_result_bus_arbiter: a 4-requester instance plus a 3-requester
// instance for the non-power-of-two pointer wrap.
module tb_wb_result_bus_arbiter;
  logic clk;
  logic rst_n;
  logic flush;
  logic flush3;

  int n_chk;
  int n_err;

  wb_result_bus_arbiter_if #(.NUM_REQ(4), .RS_ID_WIDTH(5), .DATA_WIDTH(32)) if4 ();
  wb_result_bus_arbiter_if #(.NUM_REQ(3), .RS_ID_WIDTH(5), .DATA_WIDTH(32)) if3 ();

  wb_result_bus_arbiter #(.NUM_REQ(4), .RS_ID_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (if4.slave)
  );

  wb_result_bus_arbiter #(.NUM_REQ(3), .RS_ID_WIDTH(5), .DATA_WIDTH(32)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush3),
    .bus   (if3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] std_data(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  function automatic logic [4:0] std_rs(input int i);
    return 5'(16 + i);
  endfunction

  function automatic logic [4:0] std_addr(input int i);
    return 5'(8 + i);
  endfunction

  task automatic load_std();
    for (int i = 0; i < 4; i++) begin
      if4.req_data[i]  = std_data(i);
      if4.req_rs_id[i] = std_rs(i);
      if4.req_addr[i]  = std_addr(i);
    end
    for (int i = 0; i < 3; i++) begin
      if3.req_data[i]  = std_data(i);
      if3.req_rs_id[i] = std_rs(i);
      if3.req_addr[i]  = std_addr(i);
    end
  endtask

  initial begin
    n_chk         = 0;
    n_err         = 0;
    rst_n         = 1'b1;
    flush         = 1'b0;
    flush3        = 1'b0;
    if4.req_valid = '0;
    if4.out_ready = 1'b0;
    if3.req_valid = '0;
    if3.out_ready = 1'b0;
    load_std();
    #1 rst_n = 1'b0;
    #2;
    check("reset out_valid", 64'(if4.out_valid), 64'd0);
    check("reset out_data", 64'(if4.out_data), 64'd0);
    check("reset out_src", 64'(if4.out_src), 64'd0);
    check("reset req_ready", 64'(if4.req_ready), 64'd0);
    #9 rst_n = 1'b1;

    // Single requester 1.
    if4.req_data[1]  = 32'hDEAD_BEEF;
    if4.req_addr[1]  = 5'd7;
    if4.req_rs_id[1] = 5'd3;
    if4.req_valid    = 4'b0010;
    if4.out_ready    = 1'b1;
    #1 check("single req_ready", 64'(if4.req_ready), 64'b0010);
    tick();
    check("single out_valid", 64'(if4.out_valid), 64'd1);
    check("single out_data", 64'(if4.out_data), 64'hDEAD_BEEF);
    check("single out_addr", 64'(if4.out_addr), 64'd7);
    check("single out_rs_id", 64'(if4.out_rs_id), 64'd3);
    check("single out_src", 64'(if4.out_src), 64'd1);

    // Round robin from ptr=2 with all valid and no backpressure.
    load_std();
    if4.req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 6; k++) begin
      int g;
      g = (2 + k) % 4;
      check($sformatf("rr req_ready %0d", k), 64'(if4.req_ready), 64'(1 << g));
      tick();
      check($sformatf("rr out_src %0d", k), 64'(if4.out_src), 64'(g));
      check($sformatf("rr out_data %0d", k), 64'(if4.out_data), 64'(std_data(g)));
      check($sformatf("rr out_rs_id %0d", k), 64'(if4.out_rs_id), 64'(std_rs(g)));
    end

    // Drain; ptr is now 0.
    if4.req_valid = 4'b0000;
    tick();
    check("drain out_valid", 64'(if4.out_valid), 64'd0);

    // Backpressure: two grants then stall.
    if4.req_valid = 4'b1111;
    if4.out_ready = 1'b0;
    #1 check("bp grant0", 64'(if4.req_ready), 64'b0001);
    tick();
    check("bp head src0", 64'(if4.out_src), 64'd0);
    check("bp grant1", 64'(if4.req_ready), 64'b0010);
    tick();
    check("bp full ready", 64'(if4.req_ready), 64'b0000);
    check("bp full data", 64'(if4.out_data), 64'(std_data(0)));
    tick();
    check("bp hold valid", 64'(if4.out_valid), 64'd1);
    check("bp hold src", 64'(if4.out_src), 64'd0);
    if4.out_ready = 1'b1;
    #1 check("bp bubble ready", 64'(if4.req_ready), 64'b0000);
    tick();
    check("bp pop head src1", 64'(if4.out_src), 64'd1);
    check("bp grant2", 64'(if4.req_ready), 64'b0100);
    tick();
    check("bp head src2", 64'(if4.out_src), 64'd2);
    check("bp grant3", 64'(if4.req_ready), 64'b1000);

    // Fill to count=2 with entries 2,1 leaving ptr=2.
    if4.req_valid = 4'b0010;
    if4.out_ready = 1'b0;
    #1 check("pre-flush grant1", 64'(if4.req_ready), 64'b0010);
    tick();
    check("pre-flush full", 64'(if4.req_ready), 64'b0000);
    if4.req_valid = 4'b1111;
    flush         = 1'b1;
    #1 check("flush ready", 64'(if4.req_ready), 64'b0000);
    tick();
    flush = 1'b0;
    #1;
    check("flush out_valid", 64'(if4.out_valid), 64'd0);
    check("post-flush grant ptr held", 64'(if4.req_ready), 64'b0100);
    flush = 1'b1;
    #1 check("flush empty ready", 64'(if4.req_ready), 64'b0000);
    tick();
    flush = 1'b0;
    #1;
    check("flush2 out_valid", 64'(if4.out_valid), 64'd0);
    check("flush2 grant", 64'(if4.req_ready), 64'b0100);

    // Async reset with count=1 and ptr=3.
    if4.req_valid = 4'b0100;
    tick();
    check("pre-reset out_valid", 64'(if4.out_valid), 64'd1);
    check("pre-reset out_data", 64'(if4.out_data), 64'(std_data(2)));
    if4.req_valid = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    check("async reset out_valid", 64'(if4.out_valid), 64'd0);
    check("async reset out_data", 64'(if4.out_data), 64'd0);
    #1 rst_n = 1'b1;
    if4.req_valid = 4'b1111;
    if4.out_ready = 1'b1;
    #1 check("post-reset grant", 64'(if4.req_ready), 64'b0001);
    tick();
    check("post-reset out_src", 64'(if4.out_src), 64'd0);
    check("post-reset out_valid", 64'(if4.out_valid), 64'd1);
    if4.req_valid = 4'b0000;

    // NUM_REQ=3 wrap: move ptr to 2, then requesters 2 and 0 valid.
    if3.out_ready = 1'b1;
    if3.req_valid = 3'b010;
    #1 check("n3 grant1", 64'(if3.req_ready), 64'b010);
    tick();
    if3.req_valid = 3'b101;
    #1 check("n3 grant2", 64'(if3.req_ready), 64'b100);
    tick();
    check("n3 out_src2", 64'(if3.out_src), 64'd2);
    check("n3 wrap grant0", 64'(if3.req_ready), 64'b001);
    tick();
    check("n3 out_src0", 64'(if3.out_src), 64'd0);
    check("n3 ptr1 grant2", 64'(if3.req_ready), 64'b100);
    if3.req_valid = 3'b000;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
